// File: rtl/fifo_burst_in_if.sv
// Handshake and status bundle for the burst-release FIFO.
// The master side writes and requests reads. The slave side is the FIFO itself.
interface fifo_burst_in_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic                  flush;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  full;
   logic                  empty;
   logic [LW-1:0]         level;
   logic                  data_ready;
   logic                  burst_active;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, din, rd_en, flush,
      input  dout, dout_valid, full, empty, level,
             data_ready, burst_active, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en, flush,
      output dout, dout_valid, full, empty, level,
             data_ready, burst_active, overflow, underflow
   );
endinterface

// File: rtl/fifo_burst_in.sv
// Circular-buffer FIFO that collects words in IDLE and releases them in bursts
// of BURST_LEN. A burst may be paused by dropping rd_en and resumed later.
// Read data is registered, so dout and dout_valid appear one cycle after the pop.
module fifo_burst_in #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   fifo_burst_in_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic full, empty, data_ready, push, pop, mem_we;

   // Next-state logic: flush overrides everything except dout, which holds
   always_comb begin
      full       = (level_q == LW'(DEPTH));
      empty      = (level_q == '0);
      data_ready = (state_q == IDLE) && (level_q >= LW'(BURST_LEN));
      // A full FIFO drops the write even if a pop frees a slot this cycle
      push       = bus.wr_en && !full;
      pop        = bus.rd_en && ((state_q == BURST) || data_ready);
      mem_we     = push && !bus.flush;

      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;

      if (bus.flush) begin
         state_d     = IDLE;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         cnt_d       = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (bus.wr_en && full)
            overflow_d = 1'b1;
         if (bus.rd_en && (state_q == IDLE) && !data_ready)
            underflow_d = 1'b1;

         if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);

         if (pop) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            dout_d       = mem[rd_ptr_q];
            dout_valid_d = 1'b1;
         end

         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase

         // Burst bookkeeping: the BURST_LEN-th pop returns to IDLE
         if (pop) begin
            if (state_q == IDLE) begin
               if (BURST_LEN == 1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = BURST;
                  cnt_d   = CW'(1);
               end
            end else if (cnt_q == CW'(BURST_LEN - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   // Control and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // Storage array: no reset, since only written locations are ever popped
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_ptr_q] <= bus.din;
   end

   assign bus.dout         = dout_q;
   assign bus.dout_valid   = dout_valid_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.level        = level_q;
   assign bus.data_ready   = data_ready;
   assign bus.burst_active = (state_q == BURST);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_burst_in.sv
// Bench for fifo_burst_in: directed scenarios plus a randomized run.
// Expected values come from a queue-based reference model of the burst FIFO.
module tb_fifo_burst_in;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int BL    = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fifo_burst_in_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ifc ();

   fifo_burst_in #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [DW-1:0] mq [$];
   bit            m_burst;
   int            m_left;
   bit            m_ovf, m_unf, m_dv;
   logic [DW-1:0] m_dout;

   task automatic model_reset();
      mq.delete();
      m_burst = 0;
      m_left  = 0;
      m_ovf   = 0;
      m_unf   = 0;
      m_dv    = 0;
      m_dout  = '0;
   endtask

   // Drive one cycle of inputs, advance the model alongside the DUT, then
   // settle to one time unit after the edge for sampling.
   task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit fl);
      bit full_now;
      bit can_pop;
      ifc.wr_en = wr;
      ifc.din   = d;
      ifc.rd_en = rd;
      ifc.flush = fl;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         m_burst = 0;
         m_left  = 0;
         m_dv    = 0;
         m_ovf   = 0;
         m_unf   = 0;
      end else begin
         full_now = (mq.size() == DEPTH);
         can_pop  = rd && (m_burst || mq.size() >= BL);
         if (rd && !can_pop) m_unf = 1;
         if (wr && full_now) m_ovf = 1;
         m_dv = can_pop;
         if (can_pop) begin
            m_dout = mq.pop_front();
            if (!m_burst) m_left = BL - 1;
            else m_left = m_left - 1;
            m_burst = (m_left > 0);
         end
         if (wr && !full_now) mq.push_back(d);
      end
      #1;
   endtask

   task automatic do_reset();
      ifc.wr_en = 0;
      ifc.din   = '0;
      ifc.rd_en = 0;
      ifc.flush = 0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      ifc.wr_en = 0;
      ifc.din   = '0;
      ifc.rd_en = 0;
      ifc.flush = 0;
      rst_n = 1'b0;
      #12;
      checks++; if (ifc.level !== LW'(0)) begin failures++; $display("FAIL reset_level got=%0d exp=0", ifc.level); end
      checks++; if (ifc.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", ifc.empty); end
      checks++; if (ifc.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", ifc.full); end
      checks++; if (ifc.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b exp=0", ifc.dout_valid); end
      checks++; if (ifc.dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", ifc.dout); end
      checks++; if (ifc.data_ready !== 1'b0 || ifc.burst_active !== 1'b0) begin failures++; $display("FAIL reset_fsm got ready=%b active=%b exp 0/0", ifc.data_ready, ifc.burst_active); end
      checks++; if (ifc.overflow !== 1'b0 || ifc.underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got ovf=%b unf=%b exp 0/0", ifc.overflow, ifc.underflow); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_basic_burst();
      do_reset();
      for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 0);
      checks++; if (ifc.level !== LW'(4)) begin failures++; $display("FAIL basic_level got=%0d exp=4", ifc.level); end
      checks++; if (ifc.data_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", ifc.data_ready); end
      for (int i = 1; i <= 4; i++) begin
         step(0, '0, 1, 0);
         checks++; if (ifc.dout_valid !== 1'b1 || ifc.dout !== DW'(i)) begin failures++; $display("FAIL basic_dout pop=%0d got=%0d/%b exp=%0d/1", i, ifc.dout, ifc.dout_valid, i); end
         checks++; if (ifc.burst_active !== (i < 4)) begin failures++; $display("FAIL basic_active pop=%0d got=%b exp=%b", i, ifc.burst_active, (i < 4)); end
      end
      checks++; if (ifc.level !== LW'(0) || ifc.empty !== 1'b1) begin failures++; $display("FAIL basic_end_level got=%0d exp=0", ifc.level); end
      step(0, '0, 0, 0);
      checks++; if (ifc.dout_valid !== 1'b0 || ifc.dout !== DW'(4)) begin failures++; $display("FAIL basic_hold got=%0d/%b exp=4/0", ifc.dout, ifc.dout_valid); end
   endtask

   task automatic test_overflow_wrap();
      do_reset();
      // Move both pointers to mid-buffer so the later reads cross the wrap
      for (int i = 0; i < 4; i++) step(1, DW'(50 + i), 0, 0);
      for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
      for (int i = 1; i <= 10; i++) step(1, DW'(i), 0, 0);
      checks++; if (ifc.full !== 1'b1 || ifc.level !== LW'(8)) begin failures++; $display("FAIL ovf_full got full=%b level=%0d exp 1/8", ifc.full, ifc.level); end
      checks++; if (ifc.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ifc.overflow); end
      for (int i = 1; i <= 8; i++) begin
         step(0, '0, 1, 0);
         checks++; if (ifc.dout_valid !== 1'b1 || ifc.dout !== DW'(i)) begin failures++; $display("FAIL ovf_order pop=%0d got=%0d/%b exp=%0d/1", i, ifc.dout, ifc.dout_valid, i); end
      end
      checks++; if (ifc.overflow !== 1'b1 || ifc.empty !== 1'b1) begin failures++; $display("FAIL ovf_sticky got ovf=%b empty=%b exp 1/1", ifc.overflow, ifc.empty); end
   endtask

   task automatic test_pause();
      do_reset();
      for (int i = 0; i < 4; i++) step(1, DW'(100 + i), 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(0, '0, 1, 0);
         checks++; if (ifc.dout !== DW'(100 + i) || ifc.dout_valid !== 1'b1) begin failures++; $display("FAIL pause_first got=%0d exp=%0d", ifc.dout, 100 + i); end
      end
      for (int i = 0; i < 3; i++) begin
         step(0, '0, 0, 0);
         checks++; if (ifc.dout_valid !== 1'b0 || ifc.burst_active !== 1'b1 || ifc.dout !== DW'(101)) begin failures++; $display("FAIL pause_hold cyc=%0d got dv=%b act=%b dout=%0d exp 0/1/101", i, ifc.dout_valid, ifc.burst_active, ifc.dout); end
         checks++; if (ifc.data_ready !== 1'b0) begin failures++; $display("FAIL pause_ready got=%b exp=0", ifc.data_ready); end
      end
      for (int i = 2; i < 4; i++) begin
         step(0, '0, 1, 0);
         checks++; if (ifc.dout !== DW'(100 + i) || ifc.dout_valid !== 1'b1) begin failures++; $display("FAIL pause_resume got=%0d exp=%0d", ifc.dout, 100 + i); end
      end
      checks++; if (ifc.burst_active !== 1'b0 || ifc.level !== LW'(0)) begin failures++; $display("FAIL pause_end got act=%b level=%0d exp 0/0", ifc.burst_active, ifc.level); end
   endtask

   task automatic test_write_during_burst();
      do_reset();
      for (int i = 0; i < 4; i++) step(1, DW'(300 + i), 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(1, DW'(400 + i), 1, 0);
         checks++; if (ifc.level !== LW'(4)) begin failures++; $display("FAIL wdb_level cyc=%0d got=%0d exp=4", i, ifc.level); end
         checks++; if (ifc.dout !== DW'(300 + i)) begin failures++; $display("FAIL wdb_dout cyc=%0d got=%0d exp=%0d", i, ifc.dout, 300 + i); end
      end
      checks++; if (ifc.data_ready !== 1'b1 || ifc.burst_active !== 1'b0) begin failures++; $display("FAIL wdb_ready got ready=%b act=%b exp 1/0", ifc.data_ready, ifc.burst_active); end
   endtask

   task automatic test_underflow_flush();
      do_reset();
      for (int i = 0; i < 3; i++) step(1, DW'(7 + i), 0, 0);
      step(0, '0, 1, 0);
      checks++; if (ifc.dout_valid !== 1'b0 || ifc.underflow !== 1'b1 || ifc.level !== LW'(3)) begin failures++; $display("FAIL unf_flag got dv=%b unf=%b level=%0d exp 0/1/3", ifc.dout_valid, ifc.underflow, ifc.level); end
      step(0, '0, 0, 0);
      checks++; if (ifc.underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", ifc.underflow); end
      step(1, DW'(99), 1, 1);
      checks++; if (ifc.underflow !== 1'b0 || ifc.level !== LW'(0) || ifc.empty !== 1'b1) begin failures++; $display("FAIL flush_clear got unf=%b level=%0d empty=%b exp 0/0/1", ifc.underflow, ifc.level, ifc.empty); end
      checks++; if (ifc.dout_valid !== 1'b0) begin failures++; $display("FAIL flush_dv got=%b exp=0", ifc.dout_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 7; i++) step(1, DW'(500 + i), 0, 0);
      step(0, '0, 1, 0);
      checks++; if (ifc.level !== LW'(6) || ifc.burst_active !== 1'b1) begin failures++; $display("FAIL arst_pre got level=%0d act=%b exp 6/1", ifc.level, ifc.burst_active); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ifc.level !== LW'(0) || ifc.empty !== 1'b1 || ifc.full !== 1'b0) begin failures++; $display("FAIL arst_level got level=%0d empty=%b exp 0/1", ifc.level, ifc.empty); end
      checks++; if (ifc.burst_active !== 1'b0 || ifc.data_ready !== 1'b0) begin failures++; $display("FAIL arst_fsm got act=%b ready=%b exp 0/0", ifc.burst_active, ifc.data_ready); end
      checks++; if (ifc.dout !== '0 || ifc.dout_valid !== 1'b0) begin failures++; $display("FAIL arst_dout got=%0d/%b exp 0/0", ifc.dout, ifc.dout_valid); end
      checks++; if (ifc.overflow !== 1'b0 || ifc.underflow !== 1'b0) begin failures++; $display("FAIL arst_flags got %b/%b exp 0/0", ifc.overflow, ifc.underflow); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) step(1, DW'(600 + i), 0, 0);
      step(0, '0, 1, 0);
      checks++; if (ifc.dout !== DW'(600) || ifc.level !== LW'(3)) begin failures++; $display("FAIL arst_after got dout=%0d level=%0d exp 600/3", ifc.dout, ifc.level); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         bit wr, rd, fl;
         wr = ($urandom_range(0, 99) < 55);
         rd = ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 99) < 2);
         step(wr, DW'($urandom), rd, fl);
         checks++; if (ifc.level !== LW'(mq.size())) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", c, ifc.level, mq.size()); end
         checks++; if (ifc.full !== (mq.size() == DEPTH) || ifc.empty !== (mq.size() == 0)) begin failures++; $display("FAIL rand_fe cyc=%0d got full=%b empty=%b size=%0d", c, ifc.full, ifc.empty, mq.size()); end
         checks++; if (ifc.dout_valid !== m_dv || ifc.dout !== m_dout) begin failures++; $display("FAIL rand_dout cyc=%0d got=%h/%b exp=%h/%b", c, ifc.dout, ifc.dout_valid, m_dout, m_dv); end
         checks++; if (ifc.burst_active !== m_burst || ifc.data_ready !== (!m_burst && mq.size() >= BL)) begin failures++; $display("FAIL rand_fsm cyc=%0d got act=%b ready=%b exp act=%b", c, ifc.burst_active, ifc.data_ready, m_burst); end
         checks++; if (ifc.overflow !== m_ovf || ifc.underflow !== m_unf) begin failures++; $display("FAIL rand_flags cyc=%0d got %b/%b exp %b/%b", c, ifc.overflow, ifc.underflow, m_ovf, m_unf); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_burst();
      test_overflow_wrap();
      test_pause();
      test_write_during_burst();
      test_underflow_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end
endmodule
